// File: rtl/branch_ctrl_seq.sv
// branch_ctrl_seq: self-running control-step sequencer for conditional branch
// instructions. It fetches an instruction (T0-T2) using a memory handshake,
// evaluates the branch condition in T3, and updates the PC through T4-T6.
// Opcodes other than the branch opcode leave T3 for EXC, which flags them.
// A fetch that waits too long for mem_ack sets a sticky fault and parks the
// sequencer in IDLE until clear. Every output comes straight from a flop.
module branch_ctrl_seq #(
    parameter int         DATA_WIDTH = 32,
    parameter logic [4:0] BR_OPCODE  = 5'b10111,
    parameter int         MAX_WAIT   = 8
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  run,
    input  logic [DATA_WIDTH-1:0] ir,
    input  logic [DATA_WIDTH-1:0] bus,
    input  logic                  mem_ack,
    output logic                  PCout,
    output logic                  MARin,
    output logic                  IncPC,
    output logic                  memRead,
    output logic                  MDRin,
    output logic                  MDRout,
    output logic                  IRin,
    output logic                  Gra,
    output logic                  Rout,
    output logic                  CONin,
    output logic                  Yin,
    output logic                  Cout,
    output logic                  ADD,
    output logic                  Zin,
    output logic                  Zlowout,
    output logic                  PCin,
    output logic                  CON,
    output logic                  busy,
    output logic                  illegal,
    output logic                  mem_fault
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_EXC  = 4'd8;

    // Bit positions inside the strobe vector
    localparam int B_PCOUT   = 15;
    localparam int B_MARIN   = 14;
    localparam int B_INCPC   = 13;
    localparam int B_MEMREAD = 12;
    localparam int B_MDRIN   = 11;
    localparam int B_MDROUT  = 10;
    localparam int B_IRIN    = 9;
    localparam int B_GRA     = 8;
    localparam int B_ROUT    = 7;
    localparam int B_CONIN   = 6;
    localparam int B_YIN     = 5;
    localparam int B_COUT    = 4;
    localparam int B_ADD     = 3;
    localparam int B_ZIN     = 2;
    localparam int B_ZLOWOUT = 1;
    localparam int B_PCIN    = 0;

    // Branch condition decode: C2 selects the test applied to the bus value.
    function automatic logic eval_con(input logic [3:0] c2,
                                      input logic [DATA_WIDTH-1:0] b);
        logic r;
        casez (c2)
            4'b0000: r = (b == {DATA_WIDTH{1'b0}});
            4'b0001: r = (b != {DATA_WIDTH{1'b0}});
            4'b0010: r = ~b[DATA_WIDTH-1];
            4'b0011: r = b[DATA_WIDTH-1];
            4'b01??: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic [3:0]    state_r;
    logic [3:0]    state_next_s;
    logic [CW-1:0] wait_cnt_r;
    logic [CW-1:0] wait_cnt_next_s;
    logic          fault_set_s;
    logic          con_r;
    logic          con_next_s;
    logic          mem_fault_r;
    logic [15:0]   strobe_r;
    logic [15:0]   strobe_next_s;
    logic          busy_r;
    logic          illegal_r;
    logic          opcode_match_s;
    logic          unused_ir_s;

    assign opcode_match_s = (ir[31:27] == BR_OPCODE);
    // Only the opcode and C2 fields are decoded here; the rest of the IR is ignored.
    assign unused_ir_s    = ^ir;

    // Next-state, wait-counter and fault-set decision
    always_comb begin
        state_next_s    = state_r;
        wait_cnt_next_s = {CW{1'b0}};
        fault_set_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (run && !mem_fault_r) begin
                    state_next_s = S_T0;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_T0: state_next_s = S_T1;
            S_T1: begin
                // An ack in the last allowed cycle still counts as success
                if (mem_ack) begin
                    state_next_s = S_T2;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_next_s = S_IDLE;
                    fault_set_s  = 1'b1;
                end else begin
                    state_next_s    = S_T1;
                    wait_cnt_next_s = wait_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_T2: state_next_s = S_T3;
            S_T3: begin
                if (opcode_match_s) begin
                    state_next_s = S_T4;
                end else begin
                    state_next_s = S_EXC;
                end
            end
            S_T4: state_next_s = S_T5;
            S_T5: state_next_s = S_T6;
            S_T6, S_EXC: begin
                if (run) begin
                    state_next_s = S_T0;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Condition latch value: only a matching opcode in T3 updates it
    always_comb begin
        if ((state_r == S_T3) && opcode_match_s) begin
            con_next_s = eval_con(ir[22:19], bus);
        end else begin
            con_next_s = con_r;
        end
    end

    // Strobes for the state being entered, so the flops present them for the whole cycle
    always_comb begin
        strobe_next_s = 16'h0000;
        case (state_next_s)
            S_T0: begin
                strobe_next_s[B_PCOUT] = 1'b1;
                strobe_next_s[B_MARIN] = 1'b1;
                strobe_next_s[B_INCPC] = 1'b1;
            end
            S_T1: begin
                strobe_next_s[B_MEMREAD] = 1'b1;
                strobe_next_s[B_MDRIN]   = 1'b1;
            end
            S_T2: begin
                strobe_next_s[B_MDROUT] = 1'b1;
                strobe_next_s[B_IRIN]   = 1'b1;
            end
            S_T3: begin
                strobe_next_s[B_GRA]   = 1'b1;
                strobe_next_s[B_ROUT]  = 1'b1;
                strobe_next_s[B_CONIN] = 1'b1;
            end
            S_T4: begin
                strobe_next_s[B_PCOUT] = 1'b1;
                strobe_next_s[B_YIN]   = 1'b1;
            end
            S_T5: begin
                strobe_next_s[B_COUT] = 1'b1;
                strobe_next_s[B_ADD]  = 1'b1;
                strobe_next_s[B_ZIN]  = 1'b1;
            end
            S_T6: begin
                strobe_next_s[B_ZLOWOUT] = 1'b1;
                strobe_next_s[B_PCIN]    = con_next_s;
            end
            default: strobe_next_s = 16'h0000;
        endcase
    end

    // State, counter, condition, fault and registered output flops
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_r     <= S_IDLE;
            wait_cnt_r  <= {CW{1'b0}};
            con_r       <= 1'b0;
            mem_fault_r <= 1'b0;
            strobe_r    <= 16'h0000;
            busy_r      <= 1'b0;
            illegal_r   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            wait_cnt_r  <= wait_cnt_next_s;
            con_r       <= con_next_s;
            mem_fault_r <= mem_fault_r | fault_set_s;
            strobe_r    <= strobe_next_s;
            busy_r      <= (state_next_s != S_IDLE);
            illegal_r   <= (state_next_s == S_EXC);
        end
    end

    assign PCout     = strobe_r[B_PCOUT];
    assign MARin     = strobe_r[B_MARIN];
    assign IncPC     = strobe_r[B_INCPC];
    assign memRead   = strobe_r[B_MEMREAD];
    assign MDRin     = strobe_r[B_MDRIN];
    assign MDRout    = strobe_r[B_MDROUT];
    assign IRin      = strobe_r[B_IRIN];
    assign Gra       = strobe_r[B_GRA];
    assign Rout      = strobe_r[B_ROUT];
    assign CONin     = strobe_r[B_CONIN];
    assign Yin       = strobe_r[B_YIN];
    assign Cout      = strobe_r[B_COUT];
    assign ADD       = strobe_r[B_ADD];
    assign Zin       = strobe_r[B_ZIN];
    assign Zlowout   = strobe_r[B_ZLOWOUT];
    assign PCin      = strobe_r[B_PCIN];
    assign CON       = con_r;
    assign busy      = busy_r;
    assign illegal   = illegal_r;
    assign mem_fault = mem_fault_r;

endmodule
